datapath_unit: RTL and testbench

//  Execution datapath driven by control_path: 16-entry register file, function unit (ALU/shifter),
//  B-operand and bus-D muxes, and a data RAM. Consumes the control word (DR,SA,SB,FS,MB,MD,RW,MM,MW)

---
 rtl/datapath_defs.sv | 28 ++
 rtl/register_file.sv | 46 ++++
 rtl/datapath_unit.sv | 106 ++++++++++
 tb/tb_datapath_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_defs.sv
// datapath_defs: shared definitions for the execution datapath and the control logic.
//  - Default widths for the register/bus word, the RAM address and the register count.
//  - FS_* codes for all 16 function-unit operations.
package datapath_defs;

    localparam int DATA_W_DEF = 4;
    localparam int ADDR_W_DEF = 6;
    localparam int NREG_DEF   = 16;

    // Function-select codes. All arithmetic wraps modulo 2**DATA_W.
    localparam logic [3:0] FS_PASS_A   = 4'b0000; // F = A
    localparam logic [3:0] FS_INC      = 4'b0001; // F = A + 1
    localparam logic [3:0] FS_ADD      = 4'b0010; // F = A + B
    localparam logic [3:0] FS_ADD_INC  = 4'b0011; // F = A + B + 1
    localparam logic [3:0] FS_ADD_NOTB = 4'b0100; // F = A + ~B
    localparam logic [3:0] FS_SUB      = 4'b0101; // F = A - B
    localparam logic [3:0] FS_DEC      = 4'b0110; // F = A - 1
    localparam logic [3:0] FS_PASS_A2  = 4'b0111; // F = A (second encoding)
    localparam logic [3:0] FS_AND      = 4'b1000; // F = A & B
    localparam logic [3:0] FS_OR       = 4'b1001; // F = A | B
    localparam logic [3:0] FS_XOR      = 4'b1010; // F = A ^ B
    localparam logic [3:0] FS_NOT_A    = 4'b1011; // F = ~A
    localparam logic [3:0] FS_PASS_B   = 4'b1100; // F = B
    localparam logic [3:0] FS_SHR      = 4'b1101; // F = B >> 1, zero fill
    localparam logic [3:0] FS_SHL      = 4'b1110; // F = B << 1, zero fill
    localparam logic [3:0] FS_ZERO     = 4'b1111; // F = 0

endpackage

// File: rtl/register_file.sv
// register_file: NREG x DATA_W storage, two combinational read ports, one
// synchronous write port and an asynchronous active-low clear.
//  clk        in   rising-edge write clock
//  rst_n      in   asynchronous active-low clear of every entry
//  we         in   write enable
//  wr_idx     in   write index
//  wr_data    in   write data
//  rd_a_idx   in   read port A index
//  rd_a_data  out  R[rd_a_idx], combinational
//  rd_b_idx   in   read port B index
//  rd_b_data  out  R[rd_b_idx], combinational
// A read of the entry being written returns the old value until the edge.
module register_file
    import datapath_defs::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF,
    localparam int IDX_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_a_idx,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic [IDX_W-1:0]  rd_b_idx,
    output logic [DATA_W-1:0] rd_b_data
);

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wr_idx] <= wr_data;
        end
    end

    assign rd_a_data = regs[rd_a_idx];
    assign rd_b_data = regs[rd_b_idx];

endmodule

// File: rtl/datapath_unit.sv
// datapath_unit: execution datapath driven by the control word.
// Register file, function unit (ALU/shifter), B-operand and bus-D muxes,
// RAM address mux and a data RAM with combinational read.
//  clk_main  in   system clock, state updates on the rising edge
//  reset     in   asynchronous active-low reset (clears the register file only)
//  DR/SA/SB  in   destination / A-operand / B-operand register indices
//  FS        in   function-select code (see datapath_defs)
//  MB        in   B-mux: 0 = R[SB], 1 = zero-extended constant SB
//  MD        in   D-mux: 0 = function result F, 1 = RAM read data
//  RW        in   register write enable
//  MM        in   address mux: 0 = BusA zero-extended, 1 = PC
//  MW        in   RAM write enable
//  PC        in   program counter
//  BusA      out  R[SA], combinational
//  Z         out  1 when F == 0, combinational
//  Addr      out  current RAM address
module datapath_unit
    import datapath_defs::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic              clk_main,
    input  logic              reset,
    input  logic [3:0]        DR,
    input  logic [3:0]        SA,
    input  logic [3:0]        SB,
    input  logic [3:0]        FS,
    input  logic              MB,
    input  logic              MD,
    input  logic              RW,
    input  logic              MM,
    input  logic              MW,
    input  logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] BusA,
    output logic              Z,
    output logic [ADDR_W-1:0] Addr
);

    logic [DATA_W-1:0] reg_b;
    logic [DATA_W-1:0] bus_b;
    logic [DATA_W-1:0] f;
    logic [DATA_W-1:0] bus_d;
    logic [DATA_W-1:0] ram_rd;
    logic [DATA_W-1:0] ram [2**ADDR_W];

    register_file #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_register_file (
        .clk       (clk_main),
        .rst_n     (reset),
        .we        (RW),
        .wr_idx    (DR),
        .wr_data   (bus_d),
        .rd_a_idx  (SA),
        .rd_a_data (BusA),
        .rd_b_idx  (SB),
        .rd_b_data (reg_b)
    );

    assign bus_b = MB ? DATA_W'(SB) : reg_b;

    always_comb begin
        f = '0;
        case (FS)
            FS_PASS_A:   f = BusA;
            FS_INC:      f = BusA + DATA_W'(1);
            FS_ADD:      f = BusA + bus_b;
            FS_ADD_INC:  f = BusA + bus_b + DATA_W'(1);
            FS_ADD_NOTB: f = BusA + ~bus_b;
            FS_SUB:      f = BusA - bus_b;
            FS_DEC:      f = BusA - DATA_W'(1);
            FS_PASS_A2:  f = BusA;
            FS_AND:      f = BusA & bus_b;
            FS_OR:       f = BusA | bus_b;
            FS_XOR:      f = BusA ^ bus_b;
            FS_NOT_A:    f = ~BusA;
            FS_PASS_B:   f = bus_b;
            FS_SHR:      f = bus_b >> 1;
            FS_SHL:      f = bus_b << 1;
            FS_ZERO:     f = '0;
            default:     f = '0;
        endcase
    end

    // Z reflects the function result only, so branches see it in the same cycle
    // regardless of what the D-mux selects.
    assign Z = (f == '0);

    assign Addr = MM ? PC : ADDR_W'(BusA);

    // Combinational read of the current address; a simultaneous write lands at the
    // edge, so the D-mux forwards the pre-write word to the register file.
    assign ram_rd = ram[Addr];
    assign bus_d  = MD ? ram_rd : f;

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk_main) begin
        if (MW) begin
            ram[Addr] <= bus_b;
        end
    end

endmodule

// File: tb/tb_datapath_unit.sv
module tb_datapath_unit;

    logic       clk_main;
    logic       reset;
    logic [3:0] DR, SA, SB, FS;
    logic       MB, MD, RW, MM, MW;
    logic [5:0] PC;
    logic [3:0] BusA;
    logic       Z;
    logic [5:0] Addr;

    int n_checks = 0;
    int n_errors = 0;

    datapath_unit dut (
        .clk_main (clk_main),
        .reset    (reset),
        .DR       (DR),
        .SA       (SA),
        .SB       (SB),
        .FS       (FS),
        .MB       (MB),
        .MD       (MD),
        .RW       (RW),
        .MM       (MM),
        .MW       (MW),
        .PC       (PC),
        .BusA     (BusA),
        .Z        (Z),
        .Addr     (Addr)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk_main = 1'b0;
        forever #5 clk_main = ~clk_main;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    logic [3:0] m_reg [16];
    logic [3:0] m_ram [64];
    bit         m_ram_ok [64];

    // Function unit from the operation table, in plain integer arithmetic.
    function automatic logic [3:0] ref_f(input logic [3:0] fs, input logic [3:0] a, input logic [3:0] b);
        int ai, bi, r;
        ai = int'(a);
        bi = int'(b);
        case (int'(fs))
            0, 7:    r = ai;
            1:       r = ai + 1;
            2:       r = ai + bi;
            3:       r = ai + bi + 1;
            4:       r = ai + (15 - bi);
            5:       r = ai - bi + 16;
            6:       r = ai + 15;
            8:       r = ai & bi;
            9:       r = ai | bi;
            10:      r = ai ^ bi;
            11:      r = 15 - ai;
            12:      r = bi;
            13:      r = bi / 2;
            14:      r = bi * 2;
            default: r = 0;
        endcase
        return 4'(r % 16);
    endfunction

    function automatic logic [3:0] ref_b();
        return MB ? SB : m_reg[SB];
    endfunction

    function automatic logic [5:0] ref_addr();
        return MM ? PC : {2'b00, m_reg[SA]};
    endfunction

    function automatic void model_clear_regs();
        for (int i = 0; i < 16; i++) m_reg[i] = 4'h0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] dr, input logic [3:0] sa, input logic [3:0] sb,
                         input logic [3:0] fs, input logic mb, input logic md, input logic rw,
                         input logic mm, input logic mw, input logic [5:0] pc);
        DR = dr; SA = sa; SB = sb; FS = fs;
        MB = mb; MD = md; RW = rw; MM = mm; MW = mw; PC = pc;
    endtask

    // Advance one clock: the model commits using read-before-write values.
    task automatic tick();
        logic [3:0] b, f, d;
        logic [5:0] a;
        b = ref_b();
        f = ref_f(FS, m_reg[SA], b);
        a = ref_addr();
        d = MD ? m_ram[a] : f;
        @(posedge clk_main);
        #1;
        if (RW) m_reg[DR] = d;
        if (MW) begin
            m_ram[a]    = b;
            m_ram_ok[a] = 1'b1;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0] dr, sa, sb, fs;
        logic       mb, md, rw, mm, mw;
        logic [5:0] pc;
        logic [3:0] busa;
        logic       z;
        logic [5:0] addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] dr, input logic [3:0] sa, input logic [3:0] sb,
                                input logic [3:0] fs, input logic mb, input logic md, input logic rw,
                                input logic mm, input logic mw, input logic [5:0] pc,
                                input logic [3:0] busa, input logic z, input logic [5:0] addr);
        vec_t v;
        v.dr = dr; v.sa = sa; v.sb = sb; v.fs = fs;
        v.mb = mb; v.md = md; v.rw = rw; v.mm = mm; v.mw = mw; v.pc = pc;
        v.busa = busa; v.z = z; v.addr = addr;
        return v;
    endfunction

    initial begin
        logic [3:0] r_dr, r_sa, r_sb, r_fs;
        logic       r_mb, r_md, r_rw, r_mm, r_mw;
        logic [5:0] r_pc, e_addr;
        logic [3:0] e_f;

        //                dr    sa    sb    fs    mb md rw mm mw pc     busa  z  addr
        vecs.push_back(mk(4'd1, 4'd0, 4'd9, 4'hC, 1, 0, 1, 0, 0, 6'd0, 4'h0, 0, 6'd0));  // R1=9
        vecs.push_back(mk(4'd2, 4'd1, 4'd8, 4'hC, 1, 0, 1, 0, 0, 6'd0, 4'h9, 0, 6'd9));  // R2=8
        vecs.push_back(mk(4'd4, 4'd1, 4'd2, 4'h2, 0, 0, 1, 0, 0, 6'd0, 4'h9, 0, 6'd9));  // R4=9+8 wraps to 1
        vecs.push_back(mk(4'd0, 4'd4, 4'd4, 4'h0, 0, 0, 0, 0, 0, 6'd0, 4'h1, 0, 6'd1));
        vecs.push_back(mk(4'd0, 4'd1, 4'd1, 4'h5, 0, 0, 0, 0, 0, 6'd0, 4'h9, 1, 6'd9));  // 9-9 -> Z
        vecs.push_back(mk(4'd5, 4'd0, 4'd0, 4'h6, 0, 0, 1, 0, 0, 6'd0, 4'h0, 0, 6'd0));  // R5=0-1=F
        vecs.push_back(mk(4'd0, 4'd5, 4'd0, 4'h0, 0, 0, 0, 0, 0, 6'd0, 4'hF, 0, 6'd15));
        vecs.push_back(mk(4'd3, 4'd3, 4'd5, 4'hC, 1, 0, 1, 0, 0, 6'd0, 4'h0, 0, 6'd0));  // old R3 in write cycle
        vecs.push_back(mk(4'd0, 4'd3, 4'd0, 4'h0, 0, 0, 0, 0, 0, 6'd0, 4'h5, 0, 6'd5));  // new R3 next cycle
        vecs.push_back(mk(4'd0, 4'd3, 4'd2, 4'h0, 0, 0, 0, 0, 1, 6'd0, 4'h5, 0, 6'd5));  // RAM[5]=8
        vecs.push_back(mk(4'd6, 4'd3, 4'd2, 4'hF, 0, 1, 1, 0, 0, 6'd0, 4'h5, 1, 6'd5));  // R6=RAM[5], Z ignores MD
        vecs.push_back(mk(4'd0, 4'd6, 4'd0, 4'h0, 0, 0, 0, 0, 0, 6'd0, 4'h8, 0, 6'd8));
        vecs.push_back(mk(4'd0, 4'd6, 4'd0, 4'h0, 0, 0, 0, 1, 0, 6'd40, 4'h8, 0, 6'd40)); // PC address
        vecs.push_back(mk(4'd2, 4'd0, 4'd2, 4'hC, 1, 0, 1, 0, 0, 6'd0, 4'h0, 0, 6'd0));  // R2=2
        vecs.push_back(mk(4'd7, 4'd3, 4'd2, 4'h0, 0, 1, 1, 0, 1, 6'd0, 4'h5, 0, 6'd5));  // MW+RW: R7=old 8
        vecs.push_back(mk(4'd0, 4'd7, 4'd0, 4'h0, 0, 0, 0, 0, 0, 6'd0, 4'h8, 0, 6'd8));
        vecs.push_back(mk(4'd8, 4'd3, 4'd0, 4'h0, 0, 1, 1, 0, 0, 6'd0, 4'h5, 0, 6'd5));  // R8=RAM[5]=2
        vecs.push_back(mk(4'd0, 4'd8, 4'd0, 4'h0, 0, 0, 0, 0, 0, 6'd0, 4'h2, 0, 6'd2));
        vecs.push_back(mk(4'd9, 4'd0, 4'd9, 4'hC, 1, 0, 1, 0, 0, 6'd0, 4'h0, 0, 6'd0));  // R9=1001
        vecs.push_back(mk(4'd10, 4'd0, 4'd9, 4'hE, 0, 0, 1, 0, 0, 6'd0, 4'h0, 0, 6'd0)); // R10=0010
        vecs.push_back(mk(4'd11, 4'd0, 4'd9, 4'hD, 0, 0, 1, 0, 0, 6'd0, 4'h0, 0, 6'd0)); // R11=0100
        vecs.push_back(mk(4'd0, 4'd0, 4'd9, 4'hF, 0, 0, 0, 0, 0, 6'd0, 4'h0, 1, 6'd0));
        vecs.push_back(mk(4'd0, 4'd10, 4'd0, 4'h0, 0, 0, 0, 0, 0, 6'd0, 4'h2, 0, 6'd2));
        vecs.push_back(mk(4'd0, 4'd11, 4'd0, 4'h0, 0, 0, 0, 0, 0, 6'd0, 4'h4, 0, 6'd4));
        vecs.push_back(mk(4'd0, 4'd0, 4'd0, 4'hB, 0, 0, 0, 0, 0, 6'd0, 4'h0, 0, 6'd0));  // ~0 = F
        vecs.push_back(mk(4'd0, 4'd5, 4'd0, 4'hB, 0, 0, 0, 0, 0, 6'd0, 4'hF, 1, 6'd15)); // ~F = 0
        vecs.push_back(mk(4'd12, 4'd1, 4'd2, 4'h4, 0, 0, 1, 0, 0, 6'd0, 4'h9, 0, 6'd9)); // 9+~2 = 6
        vecs.push_back(mk(4'd0, 4'd12, 4'd0, 4'h0, 0, 0, 0, 0, 0, 6'd0, 4'h6, 0, 6'd6));
        vecs.push_back(mk(4'd13, 4'd1, 4'd1, 4'h3, 0, 0, 1, 0, 0, 6'd0, 4'h9, 0, 6'd9)); // 9+9+1 = 3
        vecs.push_back(mk(4'd0, 4'd13, 4'd0, 4'h1, 0, 0, 0, 0, 0, 6'd0, 4'h3, 0, 6'd3));
        vecs.push_back(mk(4'd0, 4'd1, 4'd2, 4'h8, 0, 0, 0, 0, 0, 6'd0, 4'h9, 1, 6'd9));  // 9&2 = 0
        vecs.push_back(mk(4'd0, 4'd1, 4'd2, 4'h9, 0, 0, 0, 0, 0, 6'd0, 4'h9, 0, 6'd9));  // 9|2
        vecs.push_back(mk(4'd0, 4'd1, 4'd1, 4'hA, 0, 0, 0, 0, 0, 6'd0, 4'h9, 1, 6'd9));  // 9^9 = 0
        vecs.push_back(mk(4'd0, 4'd0, 4'd0, 4'h7, 0, 0, 0, 0, 0, 6'd0, 4'h0, 1, 6'd0));
        vecs.push_back(mk(4'd0, 4'd5, 4'd0, 4'h1, 0, 0, 0, 0, 0, 6'd0, 4'hF, 1, 6'd15)); // F+1 wraps

        for (int i = 0; i < 64; i++) m_ram_ok[i] = 1'b0;
        model_clear_regs();

        // ---- reset state ----
        reset = 1'b0;
        drive(4'd0, 4'd0, 4'd0, 4'h0, 0, 0, 0, 0, 0, 6'd0);
        repeat (2) @(posedge clk_main);
        #2;
        chk("reset_busa", {4'h0, BusA}, 8'h00);
        chk("reset_z", {7'h0, Z}, 8'h01);
        chk("reset_addr", {2'b00, Addr}, 8'h00);
        @(negedge clk_main);
        reset = 1'b1;
        @(posedge clk_main);
        #1;

        // ---- fill R0..R15 = F, then a reset pulse between edges ----
        for (int i = 0; i < 16; i++) begin
            drive(4'(i), 4'd0, 4'hF, 4'hC, 1, 0, 1, 0, 0, 6'd0);
            tick();
        end
        drive(4'd0, 4'd15, 4'd0, 4'h0, 0, 0, 0, 0, 0, 6'd0);
        #1;
        chk("fill_r15", {4'h0, BusA}, 8'h0F);
        reset = 1'b0;
        #1;
        chk("reset_pulse_busa", {4'h0, BusA}, 8'h00);
        #1;
        reset = 1'b1;
        model_clear_regs();
        for (int i = 0; i < 16; i++) begin
            SA = 4'(i);
            #0.1;
            chk($sformatf("reset_sweep_r%0d", i), {4'h0, BusA}, 8'h00);
        end

        // ---- reset held across an edge cancels a pending register write ----
        tick();
        drive(4'd3, 4'd3, 4'd7, 4'hC, 1, 0, 1, 0, 0, 6'd0);
        reset = 1'b0;
        @(posedge clk_main);
        #2;
        RW = 1'b0;
        reset = 1'b1;
        #1;
        chk("reset_cancels_write", {4'h0, BusA}, 8'h00);
        tick();

        // ---- directed vector table ----
        foreach (vecs[i]) begin
            drive(vecs[i].dr, vecs[i].sa, vecs[i].sb, vecs[i].fs, vecs[i].mb, vecs[i].md,
                  vecs[i].rw, vecs[i].mm, vecs[i].mw, vecs[i].pc);
            #2;
            chk($sformatf("vec%0d_busa", i), {4'h0, BusA}, {4'h0, vecs[i].busa});
            chk($sformatf("vec%0d_z", i), {7'h0, Z}, {7'h0, vecs[i].z});
            chk($sformatf("vec%0d_addr", i), {2'b00, Addr}, {2'b00, vecs[i].addr});
            tick();
        end

        // ---- randomized stimulus against the model ----
        for (int n = 0; n < 400; n++) begin
            r_dr = 4'($urandom_range(0, 15));
            r_sa = 4'($urandom_range(0, 15));
            r_sb = 4'($urandom_range(0, 15));
            r_fs = 4'($urandom_range(0, 15));
            r_mb = 1'($urandom_range(0, 1));
            r_md = 1'($urandom_range(0, 1));
            r_rw = 1'($urandom_range(0, 1));
            r_mm = 1'($urandom_range(0, 1));
            r_mw = ($urandom_range(0, 3) == 0);
            r_pc = 6'($urandom_range(0, 63));
            drive(r_dr, r_sa, r_sb, r_fs, r_mb, r_md, r_rw, r_mm, r_mw, r_pc);
            e_addr = ref_addr();
            // Only load from RAM words that have been written at least once.
            if (!m_ram_ok[e_addr]) MD = 1'b0;
            e_f = ref_f(FS, m_reg[SA], ref_b());
            #2;
            chk($sformatf("rnd%0d_busa", n), {4'h0, BusA}, {4'h0, m_reg[SA]});
            chk($sformatf("rnd%0d_z", n), {7'h0, Z}, {7'h0, (e_f == 4'h0)});
            chk($sformatf("rnd%0d_addr", n), {2'b00, Addr}, {2'b00, e_addr});
            tick();
        end

        // ---- final sweep of the register file ----
        drive(4'd0, 4'd0, 4'd0, 4'h0, 0, 0, 0, 0, 0, 6'd0);
        for (int i = 0; i < 16; i++) begin
            SA = 4'(i);
            #1;
            chk($sformatf("final_r%0d", i), {4'h0, BusA}, {4'h0, m_reg[i]});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
